serial_frame_sender: RTL and testbench
======================================

// Module: serial_frame_sender
// PURPOSE
//  Framed single-line serial transmitter; transmit-side counterpart of the
//  oversampling ISERDES receiver. Accepts parallel words on a valid/ready
//  handshake and drives one NRZ line (idle-high, start/data/parity/stop),
//  each bit held CLKS_PER_BIT clocks. Output feeds an OBUFDS (TMDS_33) pin.
// PARAMETERS
//  DATA_W        8  payload bits per frame, legal 1..32
//  CLKS_PER_BIT  4  clocks per bit period, legal >=2
//  STOP_BITS     1  stop bit periods, legal 1..4
//  PARITY        0  0=none, 1=even, 2=odd; parity bit follows data
// PORTS
//  clk         in   1       transmit clock, all logic on rising edge
//  aresetn     in   1       asynchronous active-low reset
//  s_data      in   DATA_W  word to send, sampled on accept
//  s_valid     in   1       s_data valid
//  s_ready     out  1       block can accept a word this cycle
//  serial_out  out  1       registered serial line, idle = 1
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       1-cycle pulse, last cycle of final stop bit
// BEHAVIOUR
//  Reset (async assert, sync release): serial_out=1, s_ready=0, busy=0,
//   frame_done=0, state=IDLE, counters 0. s_ready rises 1st clk after release.
//  Reset mid-frame: line returns high immediately; frame dropped, no frame_done.
//  States: IDLE->START->DATA->(PARITY if PARITY!=0)->STOP->IDLE.
//  Accept: s_valid&&s_ready in cycle T; s_data latched to shift reg; s_ready=0
//   from T+1. s_valid without s_ready: no effect; s_data changes after accept
//   ignored. s_valid may drop at any time without side effect.
//  Timing (C=CLKS_PER_BIT): start bit (0) on serial_out T+1..T+C.
//   Data MSB first; bit k (k=0 is MSB) occupies cycles T+1+C*(1+k)..+C-1.
//   Parity: even -> XOR of payload; odd -> inverted XOR.
//   Stop: 1 for STOP_BITS*C cycles; frame_done high in its last cycle;
//   IDLE and s_ready=1 next cycle.
//  Frame length F = 1+(1+DATA_W+(PARITY!=0)+STOP_BITS)*C clocks accept-to-
//   accept; back-to-back accept cycle is an IDLE cycle with line high.
//  Counters: bit-period counter 0..C-1 wraps, advances bit index at wrap;
//   bit index counts 0..DATA_W-1 in DATA, 0..STOP_BITS-1 in STOP; both clear
//   on state change. Width $clog2 of max+1, min 1 bit.
//  serial_out is a flop (no glitches); busy = state!=IDLE, registered.
//  Illegal parameter values: elaboration error via generate-time check.
// TESTING
//  1 Reset: aresetn=0 then release -> serial_out=1, busy=0, s_ready=1
//    one clk after release, frame_done never pulses while idle.
//  2 DATA_W=8,C=4,STOP=1,PAR=0: send 0xA5 at T -> line 0 T+1..4, then
//    1,0,1,0,0,1,0,1 each 4 clks, 1 T+37..40, frame_done at T+40, s_ready T+41.
//  3 PARITY=1, send 0x07 -> parity bit 1 after LSB; PARITY=2 -> 0.
//  4 s_valid held high, words 0x00,0xFF,0x3C -> accepts exactly 41 clks
//    apart, all three frames decoded bit-exact by reference model/receiver.
//  5 aresetn pulsed low mid-DATA of 0x55 -> serial_out=1 same cycle, no
//    frame_done, next word after release sent complete and correct.
//  6 STOP_BITS=2,C=2: stop high 4 clks; s_data toggled while busy has no
//    effect on transmitted bits.

Source files
------------

// File: rtl/serial_frame_sender_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_frame_sender_if
// Description : Word handshake between a producer and serial_frame_sender.
//               s_data  - payload word, sampled by the sender on accept
//               s_valid - producer has a word available
//               s_ready - sender can take a word this cycle
//               A transfer happens in any cycle where s_valid && s_ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface serial_frame_sender_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/serial_frame_sender.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_frame_sender
// Description : Framed single-line NRZ transmitter. Takes a parallel word on a
//               valid/ready handshake and sends start bit (0), payload MSB
//               first, optional parity bit and STOP_BITS stop bits (1). Each
//               bit is held CLKS_PER_BIT clocks. The line idles high.
// Ports       : clk        - transmit clock, rising edge
//               aresetn    - asynchronous active-low reset, sync release
//               s          - word handshake (slave side)
//               serial_out - registered serial line, idle 1
//               busy       - a frame is in progress
//               frame_done - 1-cycle pulse in last cycle of final stop bit
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_frame_sender #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0
) (
   input  wire logic             clk,
   input  wire logic             aresetn,
   serial_frame_sender_if.slave  s,
   output logic                  serial_out,
   output logic                  busy,
   output logic                  frame_done
);

   if (DATA_W < 1 || DATA_W > 32 || CLKS_PER_BIT < 2 ||
       STOP_BITS < 1 || STOP_BITS > 4 || PARITY < 0 || PARITY > 2) begin : g_param_check
      $error("serial_frame_sender: illegal parameter value");
   end

   // Bit index is shared between DATA and STOP, so size it for the larger.
   localparam int c_IDX_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
   localparam int c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_IDX_W   = (c_IDX_MAX > 1) ? $clog2(c_IDX_MAX) : 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_PENULT = c_CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [c_IDX_W-1:0] c_DATA_LAST  = c_IDX_W'(DATA_W - 1);
   localparam logic [c_IDX_W-1:0] c_STOP_LAST  = c_IDX_W'(STOP_BITS - 1);
   localparam logic               c_PAR_EN     = (PARITY != 0);
   localparam logic               c_PAR_ODD    = (PARITY == 2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0]   r_shift;
   logic                r_par;
   logic                r_line;
   logic                r_ready;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   w_shift_next;

   // Shifting left keeps the bit to send next in the MSB position; written as
   // a shift so a 1-bit payload needs no special case.
   assign w_shift_next = r_shift << 1;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_line  <= 1'b1;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_line <= 1'b1;
               r_busy <= 1'b0;
               r_cnt  <= '0;
               r_idx  <= '0;
               if (s.s_valid && r_ready) begin
                  r_state <= ST_START;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_line  <= 1'b0;
                  r_shift <= s.s_data;
                  r_par   <= (^s.s_data) ^ c_PAR_ODD;
               end else begin
                  // Ready comes up one clock after reset release.
                  r_ready <= 1'b1;
               end
            end
            ST_START: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= ST_DATA;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_line  <= r_shift[DATA_W-1];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt <= '0;
                  if (r_idx == c_DATA_LAST) begin
                     r_idx <= '0;
                     if (c_PAR_EN) begin
                        r_state <= ST_PARITY;
                        r_line  <= r_par;
                     end else begin
                        r_state <= ST_STOP;
                        r_line  <= 1'b1;
                     end
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_shift <= w_shift_next;
                     r_line  <= w_shift_next[DATA_W-1];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= ST_STOP;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_line  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               r_line <= 1'b1;
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt <= '0;
                  if (r_idx == c_STOP_LAST) begin
                     r_state <= ST_IDLE;
                     r_idx   <= '0;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  // Registered pulse: set one clock early so it is high
                  // exactly during the final stop-bit cycle.
                  if (r_idx == c_STOP_LAST && r_cnt == c_CNT_PENULT) begin
                     r_done <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_idx   <= '0;
               r_line  <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign s.s_ready  = r_ready;
   assign serial_out = r_line;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_sender.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_serial_frame_sender
// Description : Self-checking bench for serial_frame_sender. Three instances
//               with different bit period / stop / parity settings share one
//               clock and reset. Each sent word is turned into an expected
//               line waveform (bit list expanded by the bit period) and the
//               line, busy, s_ready and frame_done are compared every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_serial_frame_sender;

   localparam int c_NDUT     = 3;
   localparam int c_CPB  [3] = '{4, 4, 2};
   localparam int c_STOP [3] = '{1, 1, 2};
   localparam int c_PAR  [3] = '{0, 1, 2};
   localparam int c_TIMEOUT  = 200;

   logic       clk;
   logic       aresetn;
   logic [7:0] tb_data  [c_NDUT];
   logic       tb_valid [c_NDUT];
   logic       tb_ready [c_NDUT];
   logic       tb_line  [c_NDUT];
   logic       tb_busy  [c_NDUT];
   logic       tb_done  [c_NDUT];

   int n_chk;
   int n_pass;
   int cyc;
   int last_acc [c_NDUT];
   bit exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < c_NDUT; k++) begin : g_dut
      serial_frame_sender_if #(.DATA_W(8)) bus ();
      assign bus.s_data  = tb_data[k];
      assign bus.s_valid = tb_valid[k];
      assign tb_ready[k] = bus.s_ready;

      serial_frame_sender #(
         .DATA_W       (8),
         .CLKS_PER_BIT (c_CPB[k]),
         .STOP_BITS    (c_STOP[k]),
         .PARITY       (c_PAR[k])
      ) u_dut (
         .clk        (clk),
         .aresetn    (aresetn),
         .s          (bus),
         .serial_out (tb_line[k]),
         .busy       (tb_busy[k]),
         .frame_done (tb_done[k])
      );
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   // Reference frame: start, payload MSB first, optional parity, stop bits,
   // each bit repeated for one bit period.
   task automatic build_frame(input int k, input logic [7:0] d);
      bit bits [$];
      bits.push_back(1'b0);
      for (int b = 7; b >= 0; b--) bits.push_back(d[b]);
      if (c_PAR[k] == 1) bits.push_back(^d);
      if (c_PAR[k] == 2) bits.push_back(~(^d));
      for (int s = 0; s < c_STOP[k]; s++) bits.push_back(1'b1);
      exp_q.delete();
      foreach (bits[i])
         for (int c = 0; c < c_CPB[k]; c++) exp_q.push_back(bits[i]);
   endtask

   // Called at a negedge. hold keeps s_valid high for a back-to-back word;
   // b2b checks the spacing from the previous accept on this instance.
   task automatic send(input int k, input logic [7:0] d, input bit hold, input bit b2b);
      int n;
      int f;
      tb_data[k]  = d;
      tb_valid[k] = 1'b1;
      n = 0;
      while (!tb_ready[k] && n < c_TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (!tb_ready[k]) begin
         chk("ready_timeout", int'(tb_ready[k]), 1);
         tb_valid[k] = 1'b0;
         return;
      end
      build_frame(k, d);
      f = exp_q.size() + 1;
      if (b2b) chk("accept_spacing", cyc - last_acc[k], f);
      last_acc[k] = cyc;
      foreach (exp_q[i]) begin
         @(negedge clk);
         if (!hold) tb_valid[k] = 1'b0;
         tb_data[k] = 8'($urandom);
         chk("line",       int'(tb_line[k]),  int'(exp_q[i]));
         chk("busy",       int'(tb_busy[k]),  1);
         chk("ready_busy", int'(tb_ready[k]), 0);
         chk("frame_done", int'(tb_done[k]),  (i == exp_q.size() - 1) ? 1 : 0);
      end
      @(negedge clk);
      chk("idle_line",  int'(tb_line[k]),  1);
      chk("idle_ready", int'(tb_ready[k]), 1);
      chk("idle_busy",  int'(tb_busy[k]),  0);
      chk("idle_done",  int'(tb_done[k]),  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit prev_hold;
      bit hold;
      n_chk   = 0;
      n_pass  = 0;
      cyc     = 0;
      aresetn = 1'b0;
      for (int k = 0; k < c_NDUT; k++) begin
         tb_data[k]  = 8'h00;
         tb_valid[k] = 1'b0;
         last_acc[k] = 0;
      end

      // Reset state
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < c_NDUT; k++) begin
            chk("rst_line",  int'(tb_line[k]),  1);
            chk("rst_busy",  int'(tb_busy[k]),  0);
            chk("rst_ready", int'(tb_ready[k]), 0);
            chk("rst_done",  int'(tb_done[k]),  0);
         end
      end
      aresetn = 1'b1;
      #1;
      for (int k = 0; k < c_NDUT; k++) chk("rel_ready0", int'(tb_ready[k]), 0);
      @(negedge clk);
      for (int k = 0; k < c_NDUT; k++) begin
         chk("rel_ready1", int'(tb_ready[k]), 1);
         chk("rel_line",   int'(tb_line[k]),  1);
      end
      repeat (8) begin
         @(negedge clk);
         for (int k = 0; k < c_NDUT; k++) chk("idle_nodone", int'(tb_done[k]), 0);
      end

      // Directed frames
      send(0, 8'hA5, 1'b0, 1'b0);
      send(1, 8'h07, 1'b0, 1'b0);
      send(2, 8'h07, 1'b0, 1'b0);

      // Back-to-back with s_valid held high
      send(0, 8'h00, 1'b1, 1'b0);
      send(0, 8'hFF, 1'b1, 1'b1);
      send(0, 8'h3C, 1'b0, 1'b1);

      // Random words, random back-to-back chaining
      for (int k = 0; k < c_NDUT; k++) begin
         prev_hold = 1'b0;
         for (int r = 0; r < 5; r++) begin
            hold = (r < 4) && ($urandom_range(0, 1) == 1);
            send(k, 8'($urandom), hold, prev_hold);
            prev_hold = hold;
         end
      end

      // Reset in the middle of the data bits
      @(negedge clk);
      chk("mid_ready", int'(tb_ready[0]), 1);
      tb_data[0]  = 8'h55;
      tb_valid[0] = 1'b1;
      @(negedge clk);
      tb_valid[0] = 1'b0;
      chk("mid_start", int'(tb_line[0]), 0);
      repeat (12) @(negedge clk);
      chk("mid_busy", int'(tb_busy[0]), 1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_line",  int'(tb_line[0]),  1);
      chk("mid_rst_busy",  int'(tb_busy[0]),  0);
      chk("mid_rst_done",  int'(tb_done[0]),  0);
      chk("mid_rst_ready", int'(tb_ready[0]), 0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_hold_line", int'(tb_line[0]), 1);
         chk("mid_rst_hold_done", int'(tb_done[0]), 0);
      end
      aresetn = 1'b1;
      #1;
      chk("mid_rel_ready0", int'(tb_ready[0]), 0);
      @(negedge clk);
      chk("mid_rel_ready1", int'(tb_ready[0]), 1);
      chk("mid_rel_done",   int'(tb_done[0]),  0);
      send(0, 8'($urandom), 1'b0, 1'b0);
      send(0, 8'h55, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
